// File: rtl/pfl1_stride_detect_if.sv
// Miss-stream input and prefetch-candidate output bundle for the L1 stride detector.
// master drives misses and pf_ready; slave is the detector.
interface pfl1_stride_detect_if #(
  parameter int PC_BITS   = 32,
  parameter int ADDR_BITS = 26
);
  logic                 miss_valid;
  logic [PC_BITS-1:0]   miss_pc;
  logic [ADDR_BITS-1:0] miss_addr;
  logic                 pf_valid;
  logic                 pf_ready;
  logic [ADDR_BITS-1:0] pf_addr;
  logic [1:0]           pf_conf;
  logic [7:0]           drop_cnt;

  modport master (
    output miss_valid, miss_pc, miss_addr, pf_ready,
    input  pf_valid, pf_addr, pf_conf, drop_cnt
  );

  modport slave (
    input  miss_valid, miss_pc, miss_addr, pf_ready,
    output pf_valid, pf_addr, pf_conf, drop_cnt
  );
endinterface

// File: rtl/pfl1_stride_detect.sv
// Per-PC stride learner feeding a candidate FIFO: a miss at edge N pushes at edge N, pf_valid from N+1.
// Misses are never stalled; candidates arriving at a full FIFO (without a same-cycle pop) are dropped and counted.
module pfl1_stride_detect #(
  parameter int PC_BITS   = 32,
  parameter int ADDR_BITS = 26,
  parameter int ENTRIES   = 16,
  parameter int THRESH    = 2,
  parameter int QDEPTH    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  pfl1_stride_detect_if.slave bus
);
  localparam int IDXB = $clog2(ENTRIES);
  localparam int TAGB = PC_BITS - IDXB - 2;
  localparam int QB   = $clog2(QDEPTH);
  localparam logic [1:0]  THR   = THRESH[1:0];
  localparam logic [QB:0] QFULL = QDEPTH[QB:0];

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [1:0]           conf;
  } cand_t;

  logic                 tbl_vld    [ENTRIES];
  logic [TAGB-1:0]      tbl_tag    [ENTRIES];
  logic [ADDR_BITS-1:0] tbl_last   [ENTRIES];
  logic [ADDR_BITS-1:0] tbl_stride [ENTRIES];
  logic [1:0]           tbl_conf   [ENTRIES];

  logic [IDXB-1:0]      idx;
  logic [TAGB-1:0]      tag;
  logic                 hit;
  logic                 upd;
  logic                 emit;
  logic [ADDR_BITS-1:0] delta;
  logic [ADDR_BITS-1:0] new_stride;
  logic [1:0]           new_conf;
  cand_t                cand;

  cand_t                fifo_mem [QDEPTH];
  logic [QB-1:0]        wr_ptr;
  logic [QB-1:0]        rd_ptr;
  logic [QB:0]          count;
  logic [7:0]           drop_q;
  logic                 full;
  logic                 pop;
  logic                 push_ok;
  logic                 drop;

  // Table is read combinationally, so a miss in cycle N+1 sees the write made at edge N.
  always_comb begin
    idx        = bus.miss_pc[IDXB+1:2];
    tag        = bus.miss_pc[PC_BITS-1:IDXB+2];
    hit        = tbl_vld[idx] && (tbl_tag[idx] == tag);
    upd        = bus.miss_valid && !flush;
    delta      = bus.miss_addr - tbl_last[idx];
    new_stride = tbl_stride[idx];
    new_conf   = tbl_conf[idx];
    emit       = 1'b0;
    if (hit && (delta != '0)) begin
      if (delta == tbl_stride[idx]) begin
        if (tbl_conf[idx] != 2'd3) new_conf = tbl_conf[idx] + 2'd1;
      end else if (tbl_conf[idx] == 2'd0) begin
        new_stride = delta;
      end else begin
        new_conf = tbl_conf[idx] - 2'd1;
      end
      emit = (new_conf >= THR) && (new_stride != '0);
    end
    cand.addr = bus.miss_addr + new_stride;
    cand.conf = new_conf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl_vld[i] <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) tbl_vld[i] <= 1'b0;
    end else if (bus.miss_valid) begin
      tbl_vld[idx] <= 1'b1;
    end
  end

  // Payload fields need no reset: they are only consulted behind a valid bit.
  always_ff @(posedge clk) begin
    if (upd) begin
      tbl_tag[idx]    <= tag;
      tbl_last[idx]   <= bus.miss_addr;
      tbl_stride[idx] <= hit ? new_stride : '0;
      tbl_conf[idx]   <= hit ? new_conf : 2'd0;
    end
  end

  assign full    = (count == QFULL);
  assign pop     = bus.pf_valid && bus.pf_ready;
  assign push_ok = upd && emit && (!full || pop);
  assign drop    = upd && emit && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop_q <= '0;
      for (int i = 0; i < QDEPTH; i++) fifo_mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= cand;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.pf_valid = (count != '0);
  assign bus.pf_addr  = fifo_mem[rd_ptr].addr;
  assign bus.pf_conf  = fifo_mem[rd_ptr].conf;
  assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_pfl1_stride_detect.sv
// Random and directed stimulus for pfl1_stride_detect, checked each cycle against a
// queue-based reference model of the stride table and candidate FIFO.
module tb_pfl1_stride_detect;
  localparam int ENTRIES = 16;
  localparam int THRESH  = 2;
  localparam int QDEPTH  = 4;

  typedef struct {
    logic [25:0] a;
    int          c;
  } cand_t;

  logic clk;
  logic reset;
  logic flush;
  pfl1_stride_detect_if #(.PC_BITS(32), .ADDR_BITS(26)) bus();

  pfl1_stride_detect #(
    .PC_BITS(32), .ADDR_BITS(26), .ENTRIES(ENTRIES), .THRESH(THRESH), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit          m_vld  [ENTRIES];
  logic [31:0] m_pc   [ENTRIES];
  logic [25:0] m_last [ENTRIES];
  logic [25:0] m_str  [ENTRIES];
  int          m_conf [ENTRIES];
  int          m_drop;
  cand_t       mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
    mq.delete();
    m_drop = 0;
  endtask

  // Effect of the coming clock edge, from the current inputs.
  task automatic model_edge();
    bit          pop;
    int          i;
    logic [25:0] d;
    cand_t       c;
    pop = (mq.size() != 0) && bus.pf_ready;
    if (flush) begin
      for (int k = 0; k < ENTRIES; k++) m_vld[k] = 1'b0;
      mq.delete();
      return;
    end
    if (pop) void'(mq.pop_front());
    if (!bus.miss_valid) return;
    i = int'((bus.miss_pc >> 2) % 32'(ENTRIES));
    if (!m_vld[i] || ((m_pc[i] >> 6) != (bus.miss_pc >> 6))) begin
      m_vld[i]  = 1'b1;
      m_pc[i]   = bus.miss_pc;
      m_last[i] = bus.miss_addr;
      m_str[i]  = '0;
      m_conf[i] = 0;
      return;
    end
    d = bus.miss_addr - m_last[i];
    m_last[i] = bus.miss_addr;
    if (d == 0) return;
    if (d == m_str[i])      m_conf[i] = (m_conf[i] < 3) ? m_conf[i] + 1 : 3;
    else if (m_conf[i] == 0) m_str[i] = d;
    else                     m_conf[i] = m_conf[i] - 1;
    if (m_conf[i] >= THRESH && m_str[i] != 0) begin
      c.a = bus.miss_addr + m_str[i];
      c.c = m_conf[i];
      if (mq.size() < QDEPTH) mq.push_back(c);
      else if (m_drop < 255)  m_drop++;
    end
  endtask

  always @(negedge clk) begin
    chk("pf_valid", 32'(bus.pf_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("pf_addr", 32'(bus.pf_addr), 32'(mq[0].a));
      chk("pf_conf", 32'(bus.pf_conf), 32'(mq[0].c));
    end
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
  end

  // One clock: apply inputs after the compare, advance the model, return just after the edge.
  task automatic drive(input bit mv, input logic [31:0] pc, input logic [25:0] a,
                       input bit rdy, input bit fl);
    @(negedge clk);
    #1;
    bus.miss_valid = mv;
    bus.miss_pc    = pc;
    bus.miss_addr  = a;
    bus.pf_ready   = rdy;
    flush          = fl;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 32'h0, 26'h0, rdy, 1'b0);
  endtask

  logic [31:0] rpc  [8];
  logic [25:0] rcur [8];
  logic [25:0] rstr [8];

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.miss_valid = 1'b0;
    bus.miss_pc    = '0;
    bus.miss_addr  = '0;
    bus.pf_ready   = 1'b0;
    model_reset();
    #1;
    chk("reset_valid", 32'(bus.pf_valid), 32'd0);
    chk("reset_addr",  32'(bus.pf_addr),  32'd0);
    chk("reset_conf",  32'(bus.pf_conf),  32'd0);
    chk("reset_drop",  32'(bus.drop_cnt), 32'd0);
    #20;
    @(negedge clk);
    reset = 1'b0;

    // Stride learn, FIFO held.
    drive(1'b1, 32'h1000, 26'h100, 1'b0, 1'b0); chk("learn1_valid", 32'(bus.pf_valid), 32'd0);
    drive(1'b1, 32'h1000, 26'h104, 1'b0, 1'b0); chk("learn2_valid", 32'(bus.pf_valid), 32'd0);
    drive(1'b1, 32'h1000, 26'h108, 1'b0, 1'b0); chk("learn3_valid", 32'(bus.pf_valid), 32'd0);
    drive(1'b1, 32'h1000, 26'h10C, 1'b0, 1'b0);
    chk("learn4_valid", 32'(bus.pf_valid), 32'd1);
    chk("learn4_addr",  32'(bus.pf_addr),  32'h110);
    chk("learn4_conf",  32'(bus.pf_conf),  32'd2);
    drive(1'b1, 32'h1000, 26'h110, 1'b0, 1'b0);
    chk("learn5_hold", 32'(bus.pf_addr), 32'h110);
    idle(1'b1, 1);
    chk("learn5_addr", 32'(bus.pf_addr), 32'h114);
    chk("learn5_conf", 32'(bus.pf_conf), 32'd3);
    idle(1'b1, 1);
    chk("learn_drained", 32'(bus.pf_valid), 32'd0);

    // Stride break: conf 3 -> 2 still emits with the old stride, then decays and relearns 12.
    drive(1'b1, 32'h1000, 26'h11C, 1'b0, 1'b0);
    chk("brk1_addr", 32'(bus.pf_addr), 32'h120);
    chk("brk1_conf", 32'(bus.pf_conf), 32'd2);
    drive(1'b1, 32'h1000, 26'h128, 1'b0, 1'b0);
    drive(1'b1, 32'h1000, 26'h134, 1'b0, 1'b0);
    drive(1'b1, 32'h1000, 26'h140, 1'b0, 1'b0);
    drive(1'b1, 32'h1000, 26'h14C, 1'b0, 1'b0);
    drive(1'b1, 32'h1000, 26'h158, 1'b0, 1'b0);
    idle(1'b1, 1);
    chk("brk2_addr", 32'(bus.pf_addr), 32'h164);
    chk("brk2_conf", 32'(bus.pf_conf), 32'd2);
    idle(1'b1, 1);

    // Tag conflict at idx 0: never any candidates.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, (k % 2 == 0) ? 32'h1000 : 32'h1040, 26'(32'h200 + 4 * k), 1'b1, 1'b0);
      chk("conflict_valid", 32'(bus.pf_valid), 32'd0);
    end

    // FIFO full: five emits with pf_ready low, then an emit coinciding with a pop.
    for (int k = 0; k < 8; k++) drive(1'b1, 32'h2004, 26'(32'h3000 + 8 * k), 1'b0, 1'b0);
    chk("full_drop", 32'(bus.drop_cnt), 32'd1);
    chk("full_head", 32'(bus.pf_addr),  32'h3020);
    drive(1'b1, 32'h2004, 26'h3040, 1'b1, 1'b0);
    chk("full_pushpop_drop", 32'(bus.drop_cnt), 32'd1);
    chk("full_pushpop_head", 32'(bus.pf_addr),  32'h3028);
    chk("full_pushpop_conf", 32'(bus.pf_conf),  32'd3);
    // Backpressure 1,0,1: head advances only on ready.
    idle(1'b1, 1); chk("bp1_head", 32'(bus.pf_addr), 32'h3030);
    idle(1'b0, 1); chk("bp0_head", 32'(bus.pf_addr), 32'h3030);
    idle(1'b1, 1); chk("bp2_head", 32'(bus.pf_addr), 32'h3038);
    idle(1'b1, 3);

    // Flush: same-cycle miss ignored, drop count kept, warm-up starts over.
    for (int k = 0; k < 4; k++) drive(1'b1, 32'h1000, 26'(32'h600 + 4 * k), 1'b1, 1'b0);
    drive(1'b1, 32'h1000, 26'h610, 1'b1, 1'b1);
    chk("flush_valid", 32'(bus.pf_valid), 32'd0);
    chk("flush_drop",  32'(bus.drop_cnt), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h1000, 26'(32'h100 + 4 * k), 1'b0, 1'b0);
      chk("reflush_valid", 32'(bus.pf_valid), 32'd0);
    end
    drive(1'b1, 32'h1000, 26'h10C, 1'b0, 1'b0);
    chk("reflush_addr", 32'(bus.pf_addr), 32'h110);

    // Saturate the drop counter.
    for (int k = 0; k < 300; k++) drive(1'b1, 32'h3008, 26'(32'h9000 + 16 * k), 1'b0, 1'b0);
    chk("drop_sat", 32'(bus.drop_cnt), 32'd255);

    // Async reset mid-cycle with a full FIFO.
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("areset_valid", 32'(bus.pf_valid), 32'd0);
    chk("areset_drop",  32'(bus.drop_cnt), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Random traffic: a few PCs (some sharing an index) with noisy strides that wrap.
    rpc = '{32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'h4010, 32'h4040, 32'h4044, 32'h8020};
    for (int j = 0; j < 8; j++) begin
      rcur[j] = 26'($urandom);
      rstr[j] = 26'($urandom_range(1, 40));
      if ($urandom_range(0, 1) == 1) rstr[j] = 26'd0 - rstr[j];
    end
    for (int k = 0; k < 3000; k++) begin
      int          j;
      int          r;
      logic [25:0] a;
      j = $urandom_range(0, 7);
      r = $urandom_range(0, 15);
      if (r == 0)      a = 26'($urandom);
      else if (r == 1) a = rcur[j];
      else             a = rcur[j] + rstr[j];
      rcur[j] = a;
      drive($urandom_range(0, 3) != 0, rpc[j], a, $urandom_range(0, 2) != 0,
            $urandom_range(0, 127) == 0);
    end
    idle(1'b1, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
